mem_fabric_arbiter: RTL and testbench
=====================================

MEM_FABRIC_ARBITER -- requirements
Module: mem_fabric_arbiter

Interface
REQ-001 Parameter N_PORTS, 16: number of clients and of banks on the memory fabric.
REQ-002 Parameter LEN_W, 4: burst-length field width; a burst lasts req_len+1 beats, so 1..16 beats.
REQ-003 clk  input  1  clock; one clock domain, all logic on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  [N_PORTS-1:0]  client i requests a bank.
REQ-006 req_bank  input  [N_PORTS-1:0][3:0]  target bank index per client.
REQ-007 req_len  input  [N_PORTS-1:0][LEN_W-1:0]  burst length minus one, per client.
REQ-008 grant  output  [N_PORTS-1:0]  client i owns its requested bank this cycle; registered.
REQ-009 client_to_send  output  [N_PORTS-1:0][4:0]  per bank: bit4 = valid, bits3:0 = owning client index; drives the mem_fabric select directly; registered.
REQ-010 bank_busy  output  [N_PORTS-1:0]  bank b is inside a burst; equals client_to_send[b][4].

Function
REQ-011 Each bank SHALL run a two-state FSM: IDLE and BUSY.
REQ-012 IDLE: if one or more clients have req_valid=1 and req_bank=b, the bank SHALL pick a winner by round-robin and move to BUSY on the next edge.
- Search order starts at the bank's pointer.
- Load beat counter with the winner's req_len.
REQ-013 Latency: a request sampled at edge N SHALL see grant=1 and client_to_send valid from cycle N+1.
REQ-014 BUSY: the counter SHALL decrement once per cycle, and the bank SHALL return to IDLE after the beat with count 0.
- The owner's req_valid, req_bank and req_len are ignored while BUSY.
- A burst always runs to completion.
REQ-015 Back-to-back: in the final BUSY beat, the bank SHALL arbitrate among its pending requesters.
- The owner is excluded from this arbitration.
- If a winner exists, the bank stays BUSY with the new owner from the next cycle, with no idle bubble.
REQ-016 Round-robin: on every grant, the bank's pointer SHALL become (winner+1) mod 16.
- The pointer is unchanged when there is no grant.
REQ-017 A client SHALL hold at most one grant per cycle, since it targets one bank.
- A client may withdraw (drop req_valid) before it is granted, with no side effects.
REQ-018 A client that is already granted and still has req_valid=1 in the final beat SHALL NOT be re-granted the same bank in that arbitration.
- It may win the following arbitration.
REQ-019 Banks SHALL arbitrate independently, so up to 16 grants can be active in one cycle.
REQ-020 Idle bank outputs: client_to_send[b] SHALL be 5'b0_0000.
REQ-021 A request whose req_bank changes while it is pending SHALL be treated as a new request to the new bank.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force:
- all bank FSMs to IDLE;
- grant to 0, client_to_send to 0, bank_busy to 0;
- all pointers to 0 and all beat counters to 0.
REQ-024 A reset mid-burst SHALL abort the burst with no completion beat.
- After release, the first arbitration happens on the first rising edge with rst_n=1.
- Outputs are valid from the following cycle.

Structure
REQ-025 Package mem_fabric_pkg SHALL hold:
- N_PORTS, IDX_W=4, SEL_W=5, LEN_W;
- the bank-state enum {IDLE, BUSY};
- a typedef for the 5-bit select {valid, idx}.
REQ-026 One sub-module, rr_arbiter16, SHALL be instantiated once per bank.
- Inputs: 16-bit request vector, exclude index, pointer.
- Outputs: winner index and a found flag.
- Purely combinational.
- The bank FSM, counter and pointer stay in mem_fabric_arbiter.

Verification
REQ-027 Single request: client 3 requests bank 7, len 0, at edge N -> cycle N+1: grant[3]=1, client_to_send[7]=5'b1_0011; cycle N+2: both return to 0.
REQ-028 Contention: clients 0, 5 and 9 request bank 2 with len 1, pointer 0, requests held -> ownership sequence 0,0,5,5,9,9 with no gap; pointer then 10.
REQ-029 Fairness: all 16 clients request bank 0 continuously, len 0 -> grants rotate 0..15 then wrap to 0; each client granted exactly once per 16 cycles.
REQ-030 Parallel banks: client i requests bank 15-i, len 15, for all i -> all 16 grants high together for 16 cycles; each client_to_send[b] = {1, 15-b}.
REQ-031 Reset mid-burst: rst_n low in beat 3 of a 16-beat burst -> outputs 0 in the same cycle; after release, a pending request is regranted starting from pointer 0.
REQ-032 Withdrawal and retarget:
- Client 4 drops req_valid while bank 1 is busy -> it is never granted bank 1.
- Client 4 retargets to bank 6 (idle) -> granted bank 6 in the next cycle.

Source files
------------

// File: rtl/mem_fabric_pkg.sv
// ============================================================================
//  Module      : mem_fabric_pkg
//  Description : Shared sizes, bank FSM states and the bank select word used
//                by the memory fabric arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_fabric_pkg;

    localparam int N_PORTS = 16;
    localparam int IDX_W   = 4;
    localparam int SEL_W   = 5;
    localparam int LEN_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bank_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } sel_t;

endpackage

`default_nettype wire

// File: rtl/mem_fabric_arbiter_rr.sv
// ============================================================================
//  Module      : rr_arbiter16
//  Description : Combinational 16-way round-robin picker with one optional
//                excluded requester; search starts at the pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter16 (
    input  logic [15:0] i_req,
    input  logic        i_excl_en,
    input  logic [3:0]  i_excl_idx,
    input  logic [3:0]  i_ptr,
    output logic [3:0]  o_winner,
    output logic        o_found
);

    logic [15:0] w_masked;
    logic [3:0]  w_idx;

    always_comb begin
        w_masked = i_req;
        if (i_excl_en) begin
            w_masked[i_excl_idx] = 1'b0;
        end
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = i_ptr;
        // Index wraps naturally in 4 bits, giving the circular search order.
        for (int k = 0; k < 16; k++) begin
            w_idx = i_ptr + 4'(k);
            if (!o_found && w_masked[w_idx]) begin
                o_winner = w_idx;
                o_found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_fabric_arbiter.sv
// ============================================================================
//  Module      : mem_fabric_arbiter
//  Description : Per-bank round-robin burst arbiter; each bank owns one client
//                for req_len+1 beats with back-to-back handover.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fabric_arbiter #(
    parameter int N_PORTS = mem_fabric_pkg::N_PORTS,
    parameter int LEN_W   = mem_fabric_pkg::LEN_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              req_valid,
    input  logic [N_PORTS-1:0][3:0]         req_bank,
    input  logic [N_PORTS-1:0][LEN_W-1:0]   req_len,
    output logic [N_PORTS-1:0]              grant,
    output logic [N_PORTS-1:0][4:0]         client_to_send,
    output logic [N_PORTS-1:0]              bank_busy
);

    import mem_fabric_pkg::*;

    logic [N_PORTS-1:0]            w_locked;
    logic [N_PORTS-1:0]            w_hold;
    logic [N_PORTS-1:0][SEL_W-1:0] w_sel_nxt;
    logic [N_PORTS-1:0]            w_grant_nxt;
    logic [N_PORTS-1:0]            r_grant;

    // A client mid-burst on some bank must not pick up a second bank.
    always_comb begin
        w_locked = '0;
        for (int b = 0; b < N_PORTS; b++) begin
            if (w_hold[b]) begin
                w_locked[client_to_send[b][IDX_W-1:0]] = 1'b1;
            end
        end
    end

    genvar gb;
    for (gb = 0; gb < N_PORTS; gb++) begin : g_bank
        localparam logic [IDX_W-1:0] c_bank = IDX_W'(gb);

        bank_state_t        r_state;
        logic [LEN_W-1:0]   r_cnt;
        logic [IDX_W-1:0]   r_ptr;
        sel_t               r_sel;

        logic [N_PORTS-1:0] w_req;
        logic [IDX_W-1:0]   w_win;
        logic               w_found;
        logic               w_last;
        logic               w_arb;
        logic               w_take;
        sel_t               w_nxt;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                w_req[i] = req_valid[i] && (req_bank[i] == c_bank) && !w_locked[i];
            end
        end

        assign w_last = (r_state == BUSY) && (r_cnt == '0);
        assign w_arb  = (r_state == IDLE) || w_last;

        rr_arbiter16 u_arb (
            .i_req      (w_req),
            .i_excl_en  (w_last),
            .i_excl_idx (r_sel.idx),
            .i_ptr      (r_ptr),
            .o_winner   (w_win),
            .o_found    (w_found)
        );

        assign w_take = w_arb && w_found;

        always_comb begin
            w_nxt = r_sel;
            if (w_take) begin
                w_nxt = '{valid: 1'b1, idx: w_win};
            end else if (w_arb) begin
                w_nxt = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_ptr   <= '0;
                r_sel   <= '0;
            end else begin
                r_sel <= w_nxt;
                case (r_state)
                    IDLE: begin
                        if (w_take) begin
                            r_state <= BUSY;
                            r_cnt   <= req_len[w_win];
                            r_ptr   <= w_win + 1'b1;
                        end
                    end
                    BUSY: begin
                        if (!w_last) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_take) begin
                            r_cnt <= req_len[w_win];
                            r_ptr <= w_win + 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end

        assign w_sel_nxt[gb]      = w_nxt;
        assign w_hold[gb]         = (r_state == BUSY) && (r_cnt != '0);
        assign client_to_send[gb] = r_sel;
        assign bank_busy[gb]      = r_sel.valid;
    end

    always_comb begin
        w_grant_nxt = '0;
        for (int b = 0; b < N_PORTS; b++) begin
            if (w_sel_nxt[b][SEL_W-1]) begin
                w_grant_nxt[w_sel_nxt[b][IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_grant_nxt;
        end
    end

    assign grant = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_mem_fabric_arbiter.sv
// ============================================================================
//  Module      : tb_mem_fabric_arbiter
//  Description : Directed vector table, corner sequences and random traffic
//                against a behavioural bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_fabric_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       req_valid;
    logic [15:0][3:0]  req_bank;
    logic [15:0][3:0]  req_len;
    logic [15:0]       grant;
    logic [15:0][4:0]  client_to_send;
    logic [15:0]       bank_busy;

    always #5 clk = ~clk;

    mem_fabric_arbiter #(.N_PORTS(16), .LEN_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_bank       (req_bank),
        .req_len        (req_len),
        .grant          (grant),
        .client_to_send (client_to_send),
        .bank_busy      (bank_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural model: per bank, owner and beats still to run (incl. current).
    bit m_busy  [16];
    int m_owner [16];
    int m_left  [16];
    int m_ptr   [16];

    function automatic void model_reset();
        for (int b = 0; b < 16; b++) begin
            m_busy[b] = 0; m_owner[b] = 0; m_left[b] = 0; m_ptr[b] = 0;
        end
    endfunction

    function automatic void model_step(input logic [15:0] v, input logic [15:0][3:0] bk,
                                       input logic [15:0][3:0] ln);
        bit locked [16];
        for (int c = 0; c < 16; c++) locked[c] = 0;
        for (int b = 0; b < 16; b++)
            if (m_busy[b] && m_left[b] > 1) locked[m_owner[b]] = 1;
        for (int b = 0; b < 16; b++) begin
            if (m_busy[b] && m_left[b] > 1) begin
                m_left[b]--;
            end else begin
                int win = -1;
                for (int k = 0; k < 16; k++) begin
                    int c = (m_ptr[b] + k) % 16;
                    if (win < 0 && v[c] && int'(bk[c]) == b && !locked[c] &&
                        !(m_busy[b] && m_owner[b] == c))
                        win = c;
                end
                if (win >= 0) begin
                    m_busy[b] = 1; m_owner[b] = win;
                    m_left[b] = int'(ln[win]) + 1;
                    m_ptr[b]  = (win + 1) % 16;
                end else begin
                    m_busy[b] = 0;
                end
            end
        end
    endfunction

    function automatic void model_out(output logic [15:0] g, output logic [15:0][4:0] s,
                                      output logic [15:0] bz);
        g = '0; s = '0; bz = '0;
        for (int b = 0; b < 16; b++) begin
            if (m_busy[b]) begin
                bz[b] = 1'b1;
                s[b]  = {1'b1, 4'(m_owner[b])};
                g[m_owner[b]] = 1'b1;
            end
        end
    endfunction

    typedef struct {
        logic [15:0] valid;
        logic [3:0]  bank;
        logic [3:0]  len;
        logic [15:0] exp_grant;
        logic [3:0]  chk_bank;
        logic [4:0]  exp_sel;
        logic [15:0] exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [15:0] v, input logic [3:0] bk, input logic [3:0] ln,
                                input logic [15:0] eg, input logic [3:0] cb, input logic [4:0] es,
                                input logic [15:0] eb);
        vec_t t;
        t.valid = v; t.bank = bk; t.len = ln; t.exp_grant = eg;
        t.chk_bank = cb; t.exp_sel = es; t.exp_busy = eb;
        vecs.push_back(t);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [15:0]      e_grant;
    logic [15:0][4:0] e_sel;
    logic [15:0]      e_busy;
    logic [15:0][4:0] exp_par;
    int               beat;

    initial begin
        req_valid = '0;
        req_bank  = '0;
        req_len   = '0;
        rst_n     = 1'b0;
        #1;
        chk("reset_grant", grant, 16'h0);
        chk("reset_sel", client_to_send, 80'h0);
        chk("reset_busy", bank_busy, 16'h0);
        do_reset();

        // Single request, three-way contention, then full-rotation fairness.
        add(16'h0008, 4'd7, 4'd0, 16'h0008, 4'd7, 5'b10011, 16'h0080);
        add(16'h0000, 4'd7, 4'd0, 16'h0000, 4'd7, 5'b00000, 16'h0000);
        add(16'h0221, 4'd2, 4'd1, 16'h0001, 4'd2, 5'b10000, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0001, 4'd2, 5'b10000, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0020, 4'd2, 5'b10101, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0020, 4'd2, 5'b10101, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0200, 4'd2, 5'b11001, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0200, 4'd2, 5'b11001, 16'h0004);
        add(16'h0221, 4'd2, 4'd1, 16'h0001, 4'd2, 5'b10000, 16'h0004);
        add(16'h0000, 4'd2, 4'd1, 16'h0001, 4'd2, 5'b10000, 16'h0004);
        add(16'h0000, 4'd2, 4'd1, 16'h0000, 4'd2, 5'b00000, 16'h0000);
        for (int k = 0; k < 32; k++)
            add(16'hFFFF, 4'd0, 4'd0, 16'(1 << (k % 16)), 4'd0, {1'b1, 4'(k % 16)}, 16'h0001);
        add(16'h0000, 4'd0, 4'd0, 16'h0000, 4'd0, 5'b00000, 16'h0000);

        foreach (vecs[n]) begin
            req_valid = vecs[n].valid;
            for (int i = 0; i < 16; i++) begin
                req_bank[i] = vecs[n].bank;
                req_len[i]  = vecs[n].len;
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_grant", n), grant, vecs[n].exp_grant);
            chk($sformatf("vec%0d_sel", n), client_to_send[vecs[n].chk_bank], vecs[n].exp_sel);
            chk($sformatf("vec%0d_busy", n), bank_busy, vecs[n].exp_busy);
        end

        // Every client on its own bank, 16-beat bursts in parallel.
        for (int i = 0; i < 16; i++) begin
            req_bank[i] = 4'(15 - i);
            req_len[i]  = 4'd15;
            exp_par[i]  = {1'b1, 4'(i)};
        end
        for (int b = 0; b < 16; b++) exp_par[b] = {1'b1, 4'(15 - b)};
        req_valid = '1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 0) req_valid = '0;
            chk("par_grant", grant, 16'hFFFF);
            chk("par_sel", client_to_send, exp_par);
        end
        @(posedge clk); #1;
        chk("par_end", {grant, bank_busy}, 32'h0);

        // Reset in beat 3; bank 5 pointer would favour client 8 if not cleared.
        req_valid = 16'h0104;
        req_bank[2] = 4'd5; req_bank[8] = 4'd5;
        req_len[2]  = 4'd15; req_len[8]  = 4'd15;
        @(posedge clk); #1;
        chk("rst_pre_sel", client_to_send[5], 5'b10010);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 16'h0);
        chk("rst_sel", client_to_send, 80'h0);
        chk("rst_busy", bank_busy, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_regrant_sel", client_to_send[5], 5'b10010);
        chk("rst_regrant_grant", grant, 16'h0004);

        // Withdrawal from a busy bank, then retarget to an idle bank.
        do_reset();
        req_valid = 16'h0011;
        req_bank[0] = 4'd1; req_len[0] = 4'd15;
        req_bank[4] = 4'd1; req_len[4] = 4'd0;
        @(posedge clk); #1;
        chk("wd_owner", client_to_send[1], 5'b10000);
        chk("wd_grant", grant, 16'h0001);
        req_valid = 16'h0000;
        repeat (2) begin
            @(posedge clk); #1;
            chk("wd_dropped", grant, 16'h0001);
        end
        req_valid = 16'h0010;
        @(posedge clk); #1;
        chk("wd_pending", grant, 16'h0001);
        req_bank[4] = 4'd6;
        @(posedge clk); #1;
        chk("retarget_sel", client_to_send[6], 5'b10100);
        chk("retarget_grant", grant, 16'h0011);
        req_valid = 16'h0000;
        for (beat = 6; beat <= 19; beat++) begin
            @(posedge clk); #1;
            chk("wd_bank1", client_to_send[1], (beat <= 16) ? 5'b10000 : 5'b00000);
            if (beat == 6) chk("retarget_end", client_to_send[6], 5'b00000);
        end

        // Random traffic against the model, with one reset in the middle.
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc == 400) do_reset();
            for (int i = 0; i < 16; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 6);
                req_bank[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                           : 4'($urandom_range(0, 3));
                req_len[i]   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                           : 4'($urandom_range(0, 3));
            end
            @(posedge clk);
            model_step(req_valid, req_bank, req_len);
            #1;
            model_out(e_grant, e_sel, e_busy);
            chk("rand_grant", grant, e_grant);
            chk("rand_sel", client_to_send, e_sel);
            chk("rand_busy", bank_busy, e_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
